sobel_8: RTL and testbench
==========================

# sobel_8

Downstream consumer of the 3x3 window reader: pulls one window per cycle from the padded-frame memory stage and computes the Sobel gradient magnitude |Gx|+|Gy|, saturated to 8 bits. It writes each result back through that stage's `wr`/`pixelw` write port. The block owns frame sequencing: it drives `rd` for exactly one frame's worth of windows, drains its pipeline, then pulses `done`.

## Interface
- `IMG_W`, default 256: output pixels per row, i.e. window positions per row.
- `IMG_H`, default 32: output rows per frame.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to process one frame; honoured only in IDLE.
- `pixelr1`..`pixelr9` in 8 each: window pixels, row-major (p1 p2 p3 / p4 p5 p6 / p7 p8 p9). Valid the cycle after `rd` was high.
- `thresh` in 8: binarisation threshold; used only with `SOBEL_THRESH_EN`.
- `rd` out 1: window-read strobe to the upstream reader.
- `wr` out 1: result-write strobe.
- `pixelw` out 8: result pixel, valid while `wr`=1.
- `busy` out 1: high from RUN entry until `done`.
- `done` out 1: one-cycle pulse at end of frame.

## Operation
- **FSM states:** IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on `start`.
  - RUN→DRAIN after issuing `IMG_W*IMG_H` reads.
  - DRAIN→DONE when the pipeline is empty (last `wr` issued).
  - DONE→IDLE unconditionally after 1 cycle.
- **RUN:**
  - `rd`=1 every cycle; no gaps.
  - Read counter `rd_cnt` is 15 bits, counts 0..`IMG_W*IMG_H`-1, then forces `rd` low.
- **Input sampling:** `in_valid` is `rd` delayed one register; pixels are sampled when `in_valid`=1.
- **Datapath** (3 registered stages, valid bit travels alongside):
  - S1: Gx = (p3+2p6+p9)-(p1+2p4+p7); Gy = (p7+2p8+p9)-(p1+2p2+p3). Signed, 11 bits (range ±1020).
  - S2: mag = |Gx|+|Gy|. Unsigned, 11 bits (max 2040).
  - S3: `pixelw` = (mag>255) ? 255 : mag[7:0]; `wr` = S2 valid.
- `start` while `busy` is ignored, with no effect on the counters.
- Reset (any time, including mid-frame):
  - all outputs 0, FSM to IDLE, counters and pipeline valids cleared;
  - partial-frame data is discarded and no `done` is issued.
- `busy` = (state is RUN or DRAIN).
- `done` = (state is DONE).

## Timing
- `start` sampled high at edge 0 → `rd`=1 for cycles 1..N, where N = `IMG_W*IMG_H` = 8192 by default.
- Read latency: `rd` at cycle t → pixels valid at t+1 → S1 at t+2 → S2 at t+3 → `wr`/`pixelw` at t+4.
- First `wr` at cycle 5; last `wr` at cycle N+4; `done` at cycle N+5; `busy` low from N+5.
- Exactly N `wr` pulses per frame, contiguous, in raster order.
- Earliest next frame: `start` accepted at cycle N+6 (back in IDLE).

## Configuration
- `SOBEL_THRESH_EN` defined:
  - S3 output is `pixelw` = (sat_mag >= `thresh`) ? 255 : 0.
  - Comparison uses the saturated value.
- `SOBEL_THRESH_EN` undefined:
  - `pixelw` = saturated magnitude.
  - `thresh` is unused.
- Latency is identical in both builds.

## Structure
- Package `sobel_pkg`:
  - `IMG_W`/`IMG_H` defaults;
  - `GRAD_W`=11 and `PIX_W`=8 constants;
  - FSM state typedef (IDLE/RUN/DRAIN/DONE).
- Sub-module `sobel_core`: the 3-stage datapath, with inputs p1..p9, `in_valid`, `thresh` and outputs `pixelw`, `wr`, `pipe_empty`.
- Top `sobel_8`: FSM, read counter, `rd` delay register, `busy`/`done`.

## Test plan
- Flat frame: all pixels 77 → 8192 `wr` pulses, all with `pixelw`=0; `done` at cycle 8197.
- Vertical edge: left column 10, middle 20, right 30 (rows identical) → `pixelw`=80 (Gx=80, Gy=0).
- Saturation: left column 0, right column 255, top row = bottom row → Gx=1020 → `pixelw`=255.
- With `SOBEL_THRESH_EN`, `thresh`=64:
  - vertical-edge window → 255;
  - gradient 40 (columns 10/15/20) → 0.
- `start` pulsed again at cycles 100 and 8196 → ignored: still exactly 8192 writes and one `done`.
- Reset asserted at cycle 3000 for 2 cycles → `rd`/`wr`/`busy`/`done` drop to 0 immediately.
  - A new `start` then gives a full 8192-write frame, with `rd_cnt` starting from 0.

Source files
------------

// File: rtl/sobel_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sobel_pkg : shared constants, FSM encoding and helpers for sobel_8          |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
package sobel_pkg;

    localparam int IMG_W_DEFAULT = 256;
    localparam int IMG_H_DEFAULT = 32;
    localparam int GRAD_W        = 11;
    localparam int PIX_W         = 8;
    localparam int CNT_W         = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Magnitude of a two's-complement gradient; |-1020| still fits in GRAD_W.
    function automatic logic [GRAD_W-1:0] abs_grad(input logic signed [GRAD_W-1:0] g);
        return g[GRAD_W-1] ? $unsigned(-g) : $unsigned(g);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sobel_if : window-read and result-write port of the padded-frame stage     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface sobel_if;
    import sobel_pkg::*;

    logic             rd;
    logic [PIX_W-1:0] pixelr1;
    logic [PIX_W-1:0] pixelr2;
    logic [PIX_W-1:0] pixelr3;
    logic [PIX_W-1:0] pixelr4;
    logic [PIX_W-1:0] pixelr5;
    logic [PIX_W-1:0] pixelr6;
    logic [PIX_W-1:0] pixelr7;
    logic [PIX_W-1:0] pixelr8;
    logic [PIX_W-1:0] pixelr9;
    logic             wr;
    logic [PIX_W-1:0] pixelw;

    modport master (
        output rd, wr, pixelw,
        input  pixelr1, pixelr2, pixelr3, pixelr4, pixelr5,
               pixelr6, pixelr7, pixelr8, pixelr9
    );

    modport slave (
        input  rd, wr, pixelw,
        output pixelr1, pixelr2, pixelr3, pixelr4, pixelr5,
               pixelr6, pixelr7, pixelr8, pixelr9
    );

endinterface
`default_nettype wire

// File: rtl/sobel_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sobel_core : 3-stage |Gx|+|Gy| datapath, saturated to 8 bits               |
// | Build macro: SOBEL_THRESH_EN selects binarised output against thresh       |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module sobel_core
    import sobel_pkg::*;
(
    input  wire              clk,
    input  wire              rst,
    input  wire [PIX_W-1:0]  p1,
    input  wire [PIX_W-1:0]  p2,
    input  wire [PIX_W-1:0]  p3,
    input  wire [PIX_W-1:0]  p4,
    input  wire [PIX_W-1:0]  p5,
    input  wire [PIX_W-1:0]  p6,
    input  wire [PIX_W-1:0]  p7,
    input  wire [PIX_W-1:0]  p8,
    input  wire [PIX_W-1:0]  p9,
    input  wire              in_valid,
    input  wire [PIX_W-1:0]  thresh,
    output logic [PIX_W-1:0] pixelw,
    output logic             wr,
    output logic             pipe_empty
);

    logic signed [GRAD_W-1:0] w_gx;
    logic signed [GRAD_W-1:0] w_gy;
    logic signed [GRAD_W-1:0] r_gx;
    logic signed [GRAD_W-1:0] r_gy;
    logic                     r_v1;
    logic [GRAD_W-1:0]        r_mag;
    logic                     r_v2;
    logic [PIX_W-1:0]         w_sat;
    logic [PIX_W-1:0]         r_pix;
    logic                     r_wr;

    // The centre pixel p5 carries zero weight in both kernels.
    logic w_unused_p5;
    assign w_unused_p5 = ^p5;

    // Zero-extended sums wrap correctly into the signed GRAD_W result.
    assign w_gx = (GRAD_W'(p3) + (GRAD_W'(p6) << 1) + GRAD_W'(p9))
                - (GRAD_W'(p1) + (GRAD_W'(p4) << 1) + GRAD_W'(p7));
    assign w_gy = (GRAD_W'(p7) + (GRAD_W'(p8) << 1) + GRAD_W'(p9))
                - (GRAD_W'(p1) + (GRAD_W'(p2) << 1) + GRAD_W'(p3));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gx  <= '0;
            r_gy  <= '0;
            r_v1  <= 1'b0;
            r_mag <= '0;
            r_v2  <= 1'b0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_gx <= w_gx;
                r_gy <= w_gy;
            end
            r_v2  <= r_v1;
            r_mag <= abs_grad(r_gx) + abs_grad(r_gy);
        end
    end

    assign w_sat = (r_mag > GRAD_W'(255)) ? PIX_W'(255) : r_mag[PIX_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix <= '0;
            r_wr  <= 1'b0;
        end else begin
            r_wr <= r_v2;
`ifdef SOBEL_THRESH_EN
            r_pix <= (w_sat >= thresh) ? {PIX_W{1'b1}} : '0;
`else
            r_pix <= w_sat;
`endif
        end
    end

`ifndef SOBEL_THRESH_EN
    logic w_unused_thresh;
    assign w_unused_thresh = ^thresh;
`endif

    assign pixelw = r_pix;
    assign wr     = r_wr;
    // Empty once the only remaining valid is the write now on the output.
    assign pipe_empty = ~(in_valid | r_v1 | r_v2);

endmodule
`default_nettype wire

// File: rtl/sobel_8.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sobel_8 : frame sequencer around sobel_core (build macro SOBEL_THRESH_EN)  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sobel_8
    import sobel_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEFAULT,
    parameter int IMG_H = IMG_H_DEFAULT
) (
    input  wire             clk,
    input  wire             rst,
    input  wire             start,
    input  wire [PIX_W-1:0] thresh,
    sobel_if.master         bus,
    output logic            busy,
    output logic            done
);

    localparam logic [CNT_W-1:0] c_LAST_RD = CNT_W'(IMG_W * IMG_H - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_rd_cnt;
    logic             r_in_valid;
    logic             w_rd;
    logic             w_last_rd;
    logic             w_pipe_empty;
    logic             w_wr;
    logic [PIX_W-1:0] w_pixelw;

    assign w_last_rd = (r_rd_cnt == c_LAST_RD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd        = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_rd = 1'b1;
                busy = 1'b1;
                if (w_last_rd) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (w_pipe_empty) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Counter only moves in RUN, so a start seen while busy cannot disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_cnt   <= '0;
            r_in_valid <= 1'b0;
        end else begin
            r_in_valid <= w_rd;
            if (r_state == ST_RUN && !w_last_rd) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end else begin
                r_rd_cnt <= '0;
            end
        end
    end

    sobel_core u_core (
        .clk        (clk),
        .rst        (rst),
        .p1         (bus.pixelr1),
        .p2         (bus.pixelr2),
        .p3         (bus.pixelr3),
        .p4         (bus.pixelr4),
        .p5         (bus.pixelr5),
        .p6         (bus.pixelr6),
        .p7         (bus.pixelr7),
        .p8         (bus.pixelr8),
        .p9         (bus.pixelr9),
        .in_valid   (r_in_valid),
        .thresh     (thresh),
        .pixelw     (w_pixelw),
        .wr         (w_wr),
        .pipe_empty (w_pipe_empty)
    );

    assign bus.rd     = w_rd;
    assign bus.wr     = w_wr;
    assign bus.pixelw = w_pixelw;

endmodule
`default_nettype wire

// File: tb/tb_sobel_8.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sobel_8 : directed self-checking bench for sobel_8                      |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module tb_sobel_8;
    import sobel_pkg::*;

    localparam int N = IMG_W_DEFAULT * IMG_H_DEFAULT;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] thresh;
    logic       busy;
    logic       done;

    sobel_if bus();

    sobel_8 dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .thresh (thresh),
        .bus    (bus),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Directed windows p1..p9 and hand-computed results.
    logic [7:0] win [0:9][0:8] = '{
        '{77, 77, 77, 77, 77, 77, 77, 77, 77},   // flat            -> 0
        '{10, 20, 30, 10, 20, 30, 10, 20, 30},   // vertical edge   -> 80
        '{0, 128, 255, 0, 128, 255, 0, 128, 255},// Gx=1020         -> 255
        '{10, 15, 20, 10, 15, 20, 10, 15, 20},   // Gx=40           -> 40
        '{10, 18, 26, 10, 18, 26, 10, 18, 26},   // Gx=64           -> 64
        '{30, 30, 30, 20, 20, 20, 10, 10, 10},   // Gy=-80          -> 80
        '{0, 32, 64, 0, 32, 64, 0, 32, 64},      // Gx=256          -> 255
        '{0, 0, 0, 0, 0, 31, 0, 0, 0},           // Gx=62           -> 62
        '{0, 0, 100, 0, 0, 255, 50, 255, 255},   // 815+715=1530    -> 255
        '{0, 0, 0, 0, 0, 127, 0, 0, 0}           // Gx=254          -> 254
    };
`ifdef SOBEL_THRESH_EN
    int exp_val [0:9] = '{0, 255, 255, 0, 255, 255, 255, 0, 255, 255};
`else
    int exp_val [0:9] = '{0, 80, 255, 40, 64, 80, 255, 62, 255, 254};
`endif

    int         checks = 0;
    int         errors = 0;
    int         cyc;
    int         rd_idx;
    int         pat_mode;
    logic       last_rd;
    logic       s_rd, s_wr, s_busy, s_done;
    logic [7:0] s_pix;

    task automatic drive_window(input int k);
        int w;
        w = (pat_mode == 0) ? 0 : k % 10;
        bus.pixelr1 = win[w][0]; bus.pixelr2 = win[w][1]; bus.pixelr3 = win[w][2];
        bus.pixelr4 = win[w][3]; bus.pixelr5 = win[w][4]; bus.pixelr6 = win[w][5];
        bus.pixelr7 = win[w][6]; bus.pixelr8 = win[w][7]; bus.pixelr9 = win[w][8];
    endtask

    // One clock: acts as the window reader and samples the DUT outputs.
    task automatic cycle_step();
        @(posedge clk);
        #1;
        cyc++;
        if (last_rd) begin
            drive_window(rd_idx);
            rd_idx++;
        end
        s_rd    = bus.rd;
        s_wr    = bus.wr;
        s_pix   = bus.pixelw;
        s_busy  = busy;
        s_done  = done;
        last_rd = bus.rd;
    endtask

    task automatic new_frame(input int mode);
        pat_mode = mode;
        rd_idx   = 0;
        last_rd  = 1'b0;
        cyc      = 0;
        start    = 1'b1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.rd !== 1'b0) begin errors++; $display("FAIL reset_rd got %b want 0", bus.rd); end
        checks++; if (bus.wr !== 1'b0) begin errors++; $display("FAIL reset_wr got %b want 0", bus.wr); end
        checks++; if (bus.pixelw !== 8'd0) begin errors++; $display("FAIL reset_pixelw got %0d want 0", bus.pixelw); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        rst = 1'b0;
        cycle_step();
        cycle_step();
        checks++; if (s_rd !== 1'b0 || s_busy !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset rd=%b busy=%b want 0/0", s_rd, s_busy);
        end
    endtask

    // Flat frame with extra start pulses in RUN (cycle 100) and DRAIN (cycle N+4).
    task automatic test_flat_frame();
        int n_rd, n_wr, n_done, first_rd, last_rdc, first_wr, last_wr, done_cyc;
        logic busy1, busy_end;
        n_rd = 0; n_wr = 0; n_done = 0; first_rd = -1; last_rdc = -1;
        first_wr = -1; last_wr = -1; done_cyc = -1; busy1 = 1'b0; busy_end = 1'b1;
        new_frame(0);
        for (int i = 0; i < N + 12; i++) begin
            cycle_step();
            start = (cyc == 100 || cyc == N + 4);
            if (cyc == 1) busy1 = s_busy;
            if (cyc == N + 5) busy_end = s_busy;
            if (s_rd) begin
                if (first_rd < 0) first_rd = cyc;
                last_rdc = cyc;
                n_rd++;
            end
            if (s_wr) begin
                checks++;
                if (s_pix !== 8'd0) begin
                    errors++; $display("FAIL flat_pixel idx %0d got %0d want 0", n_wr, s_pix);
                end
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
                n_wr++;
            end
            if (s_done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
        start = 1'b0;
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL flat_busy_c1 got %b want 1", busy1); end
        checks++; if (n_rd != N) begin errors++; $display("FAIL flat_rd_count got %0d want %0d", n_rd, N); end
        checks++; if (first_rd != 1) begin errors++; $display("FAIL flat_first_rd got %0d want 1", first_rd); end
        checks++; if (last_rdc != N) begin errors++; $display("FAIL flat_last_rd got %0d want %0d", last_rdc, N); end
        checks++; if (n_wr != N) begin errors++; $display("FAIL flat_wr_count got %0d want %0d", n_wr, N); end
        checks++; if (first_wr != 5) begin errors++; $display("FAIL flat_first_wr got %0d want 5", first_wr); end
        checks++; if (last_wr != N + 4) begin errors++; $display("FAIL flat_last_wr got %0d want %0d", last_wr, N + 4); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL flat_done_count got %0d want 1", n_done); end
        checks++; if (done_cyc != N + 5) begin errors++; $display("FAIL flat_done_cycle got %0d want %0d", done_cyc, N + 5); end
        checks++; if (busy_end !== 1'b0) begin errors++; $display("FAIL flat_busy_end got %b want 0", busy_end); end
    endtask

    // Back-to-back frame cycling through the directed window table.
    task automatic test_patterns();
        int n_wr, n_done, want;
        n_wr = 0; n_done = 0;
        new_frame(1);
        for (int i = 0; i < N + 12; i++) begin
            cycle_step();
            start = 1'b0;
            if (s_wr) begin
                want = exp_val[n_wr % 10];
                checks++;
                if (s_pix !== 8'(want)) begin
                    errors++; $display("FAIL pattern_pixel idx %0d win %0d got %0d want %0d",
                                       n_wr, n_wr % 10, s_pix, want);
                end
                n_wr++;
            end
            if (s_done) n_done++;
        end
        checks++; if (n_wr != N) begin errors++; $display("FAIL pattern_wr_count got %0d want %0d", n_wr, N); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL pattern_done_count got %0d want 1", n_done); end
    endtask

    task automatic test_reset_midframe();
        int n_rd, n_wr, n_done, n_idle_act, first_rd, first_wr, done_cyc;
        n_rd = 0; n_wr = 0; n_done = 0; n_idle_act = 0;
        first_rd = -1; first_wr = -1; done_cyc = -1;
        new_frame(0);
        while (cyc < 3000) begin
            cycle_step();
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        checks++; if (bus.rd !== 1'b0) begin errors++; $display("FAIL midreset_rd got %b want 0", bus.rd); end
        checks++; if (bus.wr !== 1'b0) begin errors++; $display("FAIL midreset_wr got %b want 0", bus.wr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done got %b want 0", done); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle_step();
            if (s_rd || s_wr || s_done || s_busy) n_idle_act++;
        end
        checks++; if (n_idle_act != 0) begin errors++; $display("FAIL postreset_activity got %0d want 0", n_idle_act); end
        new_frame(0);
        for (int i = 0; i < N + 12; i++) begin
            cycle_step();
            start = 1'b0;
            if (s_rd) begin
                if (first_rd < 0) first_rd = cyc;
                n_rd++;
            end
            if (s_wr) begin
                if (first_wr < 0) first_wr = cyc;
                n_wr++;
            end
            if (s_done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
        checks++; if (n_rd != N) begin errors++; $display("FAIL rerun_rd_count got %0d want %0d", n_rd, N); end
        checks++; if (first_rd != 1) begin errors++; $display("FAIL rerun_first_rd got %0d want 1", first_rd); end
        checks++; if (n_wr != N) begin errors++; $display("FAIL rerun_wr_count got %0d want %0d", n_wr, N); end
        checks++; if (first_wr != 5) begin errors++; $display("FAIL rerun_first_wr got %0d want 5", first_wr); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL rerun_done_count got %0d want 1", n_done); end
        checks++; if (done_cyc != N + 5) begin errors++; $display("FAIL rerun_done_cycle got %0d want %0d", done_cyc, N + 5); end
    endtask

    initial begin
        thresh   = 8'd64;
        start    = 1'b0;
        rst      = 1'b1;
        pat_mode = 0;
        rd_idx   = 0;
        last_rd  = 1'b0;
        cyc      = 0;
        bus.pixelr1 = '0; bus.pixelr2 = '0; bus.pixelr3 = '0;
        bus.pixelr4 = '0; bus.pixelr5 = '0; bus.pixelr6 = '0;
        bus.pixelr7 = '0; bus.pixelr8 = '0; bus.pixelr9 = '0;
        test_reset();
        test_flat_frame();
        test_patterns();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
